// File: rtl/controle_fetch_pkg.sv
// Shared definitions for the fetch controller.
//   estado_t            : fetch FSM state encoding (BOOT/FETCH/VALID/HALT)
//   *_DEFAULT           : default widths and PC reset address
package controle_fetch_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT  = 13;
    localparam int unsigned INSTR_WIDTH_DEFAULT = 32;
    localparam int unsigned RESET_ADDR_DEFAULT  = 0;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } estado_t;

endpackage

// File: rtl/controle_fetch_registrador_pc.sv
// Program counter register with load enable.
//   clk, rst_n : clock (rising edge) / asynchronous active-low reset
//   load       : capture d on the next rising edge
//   d          : next PC value
//   q          : current PC (RESET_VAL while in reset)
module registrador_pc
    import controle_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_VAL  = ADDR_WIDTH'(RESET_ADDR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] d,
    output logic [ADDR_WIDTH-1:0] q
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q = pc_q;

endmodule

// File: rtl/controle_fetch.sv
// Fetch controller: owns the PC, drives instruction memory and hands fetched
// words to decode over a valid/ready handshake.
//   clk, rst_n          : clock / asynchronous active-low reset
//   endereco_escolhido  : next PC chosen by the jump/branch mux (used on accept)
//   pc_atual            : PC of the instruction in flight
//   pc_mais_um          : pc_atual + 1 (wrapping), normal input of the branch mux
//   mem_req, mem_addr   : instruction-memory read request / address
//   mem_ack, mem_data   : memory response (only honoured in FETCH)
//   instr_valid, instr  : fetched instruction towards decode
//   instr_ready         : decode accepts instr this cycle
//   halt                : decoded instruction is HALT (only meaningful on accept)
//   halted              : fetch stopped until reset
module controle_fetch
    import controle_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int unsigned           INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = ADDR_WIDTH'(RESET_ADDR_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  endereco_escolhido,
    output logic [ADDR_WIDTH-1:0]  pc_atual,
    output logic [ADDR_WIDTH-1:0]  pc_mais_um,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_ready,
    input  logic                   halt,
    output logic                   halted
);

    estado_t                state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   halted_q, halted_d;
    logic                   pc_load;
    logic                   aceite;

    registrador_pc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_VAL  (RESET_ADDR)
    ) u_registrador_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (endereco_escolhido),
        .q     (pc_atual)
    );

    assign pc_mais_um = pc_atual + ADDR_WIDTH'(1);
    assign mem_addr   = pc_atual;
    // Decoded from the state flop so that an async reset drops the request
    // in the same instant.
    assign mem_req    = (state_q == ST_FETCH);
    assign aceite     = instr_valid_q & instr_ready;

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        pc_load       = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    instr_d       = mem_data;
                    instr_valid_d = 1'b1;
                    state_d       = ST_VALID;
                end
            end
            ST_VALID: begin
                if (aceite) begin
                    instr_valid_d = 1'b0;
                    if (halt) begin
                        // PC stays on the HALT instruction
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_controle_fetch.sv
// Directed bench for controle_fetch: boot sequence, streaming fetch, wait
// states, decode back-pressure, jumps with wrap, HALT and reset mid-fetch.
module tb_controle_fetch;

    localparam int AW = 13;
    localparam int IW = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] endereco_escolhido;
    logic [AW-1:0] pc_atual;
    logic [AW-1:0] pc_mais_um;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_data;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic          instr_ready;
    logic          halt;
    logic          halted;

    int n_chk  = 0;
    int n_fail = 0;
    bit auto_next = 1'b0;

    controle_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_ADDR('0)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .endereco_escolhido (endereco_escolhido),
        .pc_atual           (pc_atual),
        .pc_mais_um         (pc_mais_um),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_ack            (mem_ack),
        .mem_data           (mem_data),
        .instr_valid        (instr_valid),
        .instr              (instr),
        .instr_ready        (instr_ready),
        .halt               (halt),
        .halted             (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_fn(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {19'b0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; afterwards outputs are settled and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
        mem_data = mem_fn(mem_addr);
        if (auto_next) endereco_escolhido = pc_mais_um;
    endtask

    task automatic chk_fetch(input string tag, input logic [AW-1:0] a);
        chk({tag, "_req"}, 64'(mem_req), 64'd1);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
    endtask

    task automatic chk_valid(input string tag, input logic [AW-1:0] a);
        chk({tag, "_vld"}, 64'(instr_valid), 64'd1);
        chk({tag, "_instr"}, 64'(instr), 64'(mem_fn(a)));
        chk({tag, "_noreq"}, 64'(mem_req), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0; halt = 1'b0;
        endereco_escolhido = '0; mem_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", 64'(pc_atual), 64'd0);
        chk("rst_pc1", 64'(pc_mais_um), 64'd1);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_vld", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);

        // 1: streaming with ack and ready tied high
        rst_n = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1; auto_next = 1'b1;
        endereco_escolhido = pc_mais_um; mem_data = mem_fn(mem_addr);
        chk("boot_noreq", 64'(mem_req), 64'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            chk_fetch($sformatf("t1_f%0d", k), AW'(k));
            step();
            chk_valid($sformatf("t1_v%0d", k), AW'(k));
            step();
        end

        // 2: three wait states at address 5
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_fetch($sformatf("t2_w%0d", k), AW'(5));
            step();
        end
        chk_fetch("t2_w3", AW'(5));
        mem_ack = 1'b1;
        step();
        chk_valid("t2_v", AW'(5));

        // 3: decode stalls, address and ack noise ignored
        instr_ready = 1'b0; auto_next = 1'b0;
        for (int k = 0; k < 4; k++) begin
            endereco_escolhido = (k % 2 == 0) ? AW'(13'h1234) : AW'(13'h0777);
            step();
            chk_valid($sformatf("t3_s%0d", k), AW'(5));
            chk($sformatf("t3_pc%0d", k), 64'(pc_atual), 64'd5);
        end

        // 4: jump, then wrap from the top address
        instr_ready = 1'b1; endereco_escolhido = AW'(13'h0A0);
        step();
        chk_fetch("t4_jmp", AW'(13'h0A0));
        step();
        endereco_escolhido = AW'(13'h1FFF);
        step();
        chk_fetch("t4_top", AW'(13'h1FFF));
        chk("t4_wrap_p1", 64'(pc_mais_um), 64'd0);
        step();
        endereco_escolhido = pc_mais_um;
        step();
        chk_fetch("t4_wrap", AW'(0));

        // 5: halt at address 7
        step();
        endereco_escolhido = AW'(7);
        step();
        chk_fetch("t5_f7", AW'(7));
        step();
        instr_ready = 1'b0; halt = 1'b1;
        step();
        step();
        chk_valid("t5_nohalt", AW'(7));
        chk("t5_nohalt_h", 64'(halted), 64'd0);
        instr_ready = 1'b1; endereco_escolhido = AW'(3);
        step();
        chk("t5_halted", 64'(halted), 64'd1);
        chk("t5_vld0", 64'(instr_valid), 64'd0);
        chk("t5_pc", 64'(pc_atual), 64'd7);
        halt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            mem_ack = k[0];
            chk($sformatf("t5_req%0d", k), 64'(mem_req), 64'd0);
            step();
        end
        chk("t5_sticky", 64'(halted), 64'd1);

        // 6: reset while FETCH waits on a non-zero PC
        rst_n = 1'b0; mem_ack = 1'b1;
        #2;
        rst_n = 1'b1;
        chk("t6_h0", 64'(halted), 64'd0);
        step();
        chk_fetch("t6_f0", AW'(0));
        step();
        endereco_escolhido = AW'(9);
        step();
        mem_ack = 1'b0;
        chk_fetch("t6_f9", AW'(9));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 64'(mem_req), 64'd0);
        chk("t6_pc_async", 64'(pc_atual), 64'd0);
        chk("t6_vld_async", 64'(instr_valid), 64'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t6_ack_drop", 64'(instr_valid), 64'd0);
        chk("t6_instr_drop", 64'(instr), 64'd0);
        rst_n = 1'b1;
        chk("t6_boot", 64'(mem_req), 64'd0);
        step();
        chk_fetch("t6_restart", AW'(0));
        chk("t6_vld_idle", 64'(instr_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
